cache_channel_agent: RTL and testbench
======================================

# cache_channel_agent

Request-side agent for the randomized cache controller: it drives one requester port (opcode, addr, valid) and consumes the matching retval. In send mode it encodes one message bit per transaction by flushing, or not flushing, a run of lines. In receive mode it decodes one bit per transaction by loading the same run and counting misses. One instance sits on the sender port and one on the receiver port of the controller.

## Interface
- TAG_LEN, 8: address/tag width; must match the controller's tag width.
- CNT_W, 5: width of num_lines, threshold and miss_count; allows up to 2^CNT_W−1 lines.
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle request to begin a transaction; ignored unless IDLE.
- mode  in  1  0 = send, 1 = receive; captured at start.
- msg_bit  in  1  bit to transmit (send mode); captured at start.
- base_addr  in  TAG_LEN  first line address; captured at start.
- num_lines  in  CNT_W  number of lines k; captured at start.
- threshold  in  CNT_W  miss count needed to decode a 1; captured at start.
- opcode  out  1  to controller: 0 = load, 1 = flush.
- addr  out  TAG_LEN  to controller: line address.
- valid  out  1  to controller: request valid.
- retval  in  1  from controller: 1 = hit or completed, 0 = miss, stall or invalid.
- busy  out  1  high while a transaction is in progress.
- done  out  1  one-cycle pulse at transaction end.
- bit_out  out  1  decoded bit; held until the next start.
- miss_count  out  CNT_W  receive-mode miss tally; held until the next start.

## Operation
- FSM states: IDLE, ISSUE, RESP, DONE.
- IDLE → ISSUE on start. If num_lines = 0, go IDLE → DONE instead.
- On start, capture all inputs, clear idx, clear miss_count.
- Each line i (0 ≤ i < k) occupies two cycles, ISSUE then RESP. addr = (base_addr + i) mod 2^TAG_LEN; addresses wrap with no error.
- Send mode, msg_bit = 1: opcode = 1 and valid = 1 in both ISSUE and RESP.
- Send mode, msg_bit = 0: valid = 0 in both cycles, but the same addr sequence and the same timing are kept, so transaction length does not depend on the bit.
- Receive mode: opcode = 0, valid = 1 in ISSUE and RESP.
- retval is sampled at the end of RESP, in receive mode only. retval = 0 increments miss_count, saturating at 2^CNT_W−1.
- RESP → ISSUE with idx+1 if idx < k−1; otherwise RESP → DONE.
- DONE: pulse done. Receive mode sets bit_out = (final miss_count ≥ threshold). Send mode sets bit_out = captured msg_bit. Next state is IDLE.
- Edge cases:
  - num_lines = 0: miss_count = 0; bit_out = (threshold == 0) in receive mode, msg_bit in send mode.
  - start asserted while busy: ignored, with no effect on captured values.
  - start asserted in the DONE cycle: ignored; start is accepted in the following IDLE cycle.
- Reset, including mid-transaction: state = IDLE; opcode, addr, valid, busy, done, bit_out and miss_count all go to 0; idx and captured registers are cleared. Any partially issued run is abandoned; no cleanup requests are sent.

## Timing
- Cycle 0: start sampled at the rising edge.
- Cycle 1 + 2i: ISSUE for line i.
- Cycle 2 + 2i: RESP for line i; retval sampled at the end of this cycle.
- Cycle 2k + 1: DONE; done = 1 and busy = 0.
- bit_out and miss_count are valid from the cycle 2k + 1 edge onward.
- busy = 1 in cycles 1 … 2k.
- Transaction latency is 2k + 1 cycles regardless of mode or msg_bit.
- opcode, addr and valid are registered outputs with no combinational path from retval.
- Back-to-back: earliest next start is sampled in cycle 2k + 2.

## Structure
- Shared package/header holds:
  - OP_LOAD = 0, OP_FLUSH = 1, plus TAG_LEN defaults shared with the controller.
  - FSM state encoding (2 bits).
  - MODE_SEND / MODE_RECV.
- Single flat module. No sub-module: the FSM, the idx counter and the saturating miss counter are small enough to stay together.

## Test plan
- Send bit = 1, base_addr = 0x10, k = 3 → flush requests to 0x10, 0x11, 0x12, each with valid held for cycles 1–2, 3–4, 5–6; done in cycle 7; bit_out = 1.
- Send bit = 0, k = 3 → valid = 0 throughout; done still in cycle 7; busy pattern identical to the bit = 1 case.
- Receive, k = 4, threshold = 2, retval in RESP = 1, 0, 0, 1 → loads issued; miss_count = 2; bit_out = 1. Repeat with retval = 1, 0, 1, 1 → miss_count = 1; bit_out = 0.
- Wrap-around: base_addr = 0xFE, k = 4 → addr sequence 0xFE, 0xFF, 0x00, 0x01.
- Edge cases:
  - num_lines = 0, receive mode, threshold = 0 → done in cycle 1; bit_out = 1; no valid asserted.
  - start pulsed at cycle 3 of a running transaction → no effect on that transaction.
- Reset: rst_n dropped asynchronously mid-RESP of line 1 → all outputs are 0 immediately; after release the agent sits in IDLE; a new start runs a full, clean transaction.

Source files
------------

// File: rtl/cache_channel_agent_pkg.sv
// ============================================================================
// Module   : cache_channel_agent_pkg
// Purpose  : Opcodes, modes, defaults and FSM encoding for cache_channel_agent.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package cache_channel_agent_pkg;

    localparam int TAG_LEN_DEFAULT = 8;
    localparam int CNT_W_DEFAULT   = 5;

    localparam logic OP_LOAD   = 1'b0;
    localparam logic OP_FLUSH  = 1'b1;

    localparam logic MODE_SEND = 1'b0;
    localparam logic MODE_RECV = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_RESP  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

endpackage

`default_nettype wire

// File: rtl/cache_channel_agent.sv
// ============================================================================
// Module   : cache_channel_agent
// Purpose  : Requester agent that sends a bit by flushing a line run, or
//            receives a bit by loading the run and counting misses.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module cache_channel_agent
    import cache_channel_agent_pkg::*;
#(
    parameter int TAG_LEN = TAG_LEN_DEFAULT,
    parameter int CNT_W   = CNT_W_DEFAULT
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               i_start,
    input  logic               i_mode,
    input  logic               i_msg_bit,
    input  logic [TAG_LEN-1:0] i_base_addr,
    input  logic [CNT_W-1:0]   i_num_lines,
    input  logic [CNT_W-1:0]   i_threshold,
    output logic               o_opcode,
    output logic [TAG_LEN-1:0] o_addr,
    output logic               o_valid,
    input  logic               i_retval,
    output logic               o_busy,
    output logic               o_done,
    output logic               o_bit_out,
    output logic [CNT_W-1:0]   o_miss_count
);

    state_t             r_state;
    state_t             w_state_nxt;
    logic               r_mode;
    logic               r_msg;
    logic [CNT_W-1:0]   r_num;
    logic [CNT_W-1:0]   r_thr;
    logic [CNT_W-1:0]   r_idx;
    logic [CNT_W-1:0]   r_miss;
    logic [TAG_LEN-1:0] r_addr;
    logic               r_valid;
    logic               r_opcode;
    logic               r_bit;

    logic               w_last;
    logic               w_miss_inc;
    logic [CNT_W-1:0]   w_miss_nxt;

    assign w_last     = (r_idx == r_num - CNT_W'(1));
    assign w_miss_inc = (r_state == ST_RESP) && (r_mode == MODE_RECV) && !i_retval;
    assign w_miss_nxt = (w_miss_inc && (r_miss != {CNT_W{1'b1}})) ? r_miss + CNT_W'(1) : r_miss;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:  if (i_start) w_state_nxt = (i_num_lines == '0) ? ST_DONE : ST_ISSUE;
            ST_ISSUE: w_state_nxt = ST_RESP;
            ST_RESP:  w_state_nxt = w_last ? ST_DONE : ST_ISSUE;
            ST_DONE:  w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    // Request outputs are loaded on the edge entering each ISSUE so they are
    // purely registered; a zero send bit keeps the address walk but drops valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= ST_IDLE;
            r_mode   <= 1'b0;
            r_msg    <= 1'b0;
            r_num    <= '0;
            r_thr    <= '0;
            r_idx    <= '0;
            r_miss   <= '0;
            r_addr   <= '0;
            r_valid  <= 1'b0;
            r_opcode <= 1'b0;
            r_bit    <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            case (r_state)
                ST_IDLE: begin
                    if (i_start) begin
                        r_mode   <= i_mode;
                        r_msg    <= i_msg_bit;
                        r_num    <= i_num_lines;
                        r_thr    <= i_threshold;
                        r_idx    <= '0;
                        r_miss   <= '0;
                        r_addr   <= i_base_addr;
                        r_valid  <= (i_num_lines != '0) && ((i_mode == MODE_RECV) || i_msg_bit);
                        r_opcode <= ((i_num_lines != '0) && (i_mode == MODE_SEND) && i_msg_bit)
                                    ? OP_FLUSH : OP_LOAD;
                        if (i_num_lines == '0)
                            r_bit <= (i_mode == MODE_RECV) ? (i_threshold == '0) : i_msg_bit;
                    end
                end
                ST_RESP: begin
                    r_miss <= w_miss_nxt;
                    if (w_last) begin
                        r_valid  <= 1'b0;
                        r_opcode <= OP_LOAD;
                        r_addr   <= '0;
                        r_bit    <= (r_mode == MODE_RECV) ? (w_miss_nxt >= r_thr) : r_msg;
                    end else begin
                        r_idx  <= r_idx + CNT_W'(1);
                        r_addr <= r_addr + TAG_LEN'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_opcode     = r_opcode;
    assign o_addr       = r_addr;
    assign o_valid      = r_valid;
    assign o_busy       = (r_state == ST_ISSUE) || (r_state == ST_RESP);
    assign o_done       = (r_state == ST_DONE);
    assign o_bit_out    = r_bit;
    assign o_miss_count = r_miss;

endmodule

`default_nettype wire

// File: tb/tb_cache_channel_agent.sv
// ============================================================================
// Module   : tb_cache_channel_agent
// Purpose  : Scoreboard bench for cache_channel_agent.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_cache_channel_agent;

    logic       clk;
    logic       rst_n;
    logic       i_start;
    logic       i_mode;
    logic       i_msg_bit;
    logic [7:0] i_base_addr;
    logic [4:0] i_num_lines;
    logic [4:0] i_threshold;
    logic       o_opcode;
    logic [7:0] o_addr;
    logic       o_valid;
    logic       i_retval;
    logic       o_busy;
    logic       o_done;
    logic       o_bit_out;
    logic [4:0] o_miss_count;

    int checks   = 0;
    int failures = 0;

    typedef struct packed {
        logic       is_done;
        logic       busy;
        logic       valid;
        logic       opcode;
        logic [7:0] addr;
        logic       bit_out;
        logic [4:0] miss;
    } exp_t;

    exp_t q[$];

    cache_channel_agent #(.TAG_LEN(8), .CNT_W(5)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_start      (i_start),
        .i_mode       (i_mode),
        .i_msg_bit    (i_msg_bit),
        .i_base_addr  (i_base_addr),
        .i_num_lines  (i_num_lines),
        .i_threshold  (i_threshold),
        .o_opcode     (o_opcode),
        .o_addr       (o_addr),
        .o_valid      (o_valid),
        .i_retval     (i_retval),
        .o_busy       (o_busy),
        .o_done       (o_done),
        .o_bit_out    (o_bit_out),
        .o_miss_count (o_miss_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drives one transaction; glitch > 0 pulses a stray start in that cycle.
    task automatic run_txn(input logic mode, input logic msg, input logic [7:0] base,
                           input logic [4:0] k, input logic [4:0] thr,
                           input logic [31:0] retpat, input int glitch, input string tag);
        exp_t e;
        int   miss;
        int   ncyc;
        miss = 0;
        for (int i = 0; i < int'(k); i++) begin
            e.is_done = 1'b0;
            e.busy    = 1'b1;
            e.valid   = mode | msg;
            e.opcode  = ~mode & msg;
            e.addr    = base + 8'(i);
            e.bit_out = 1'b0;
            e.miss    = '0;
            q.push_back(e);
            q.push_back(e);
            if (mode && !retpat[i] && miss < 31) miss++;
        end
        e.is_done = 1'b1;
        e.busy    = 1'b0;
        e.valid   = 1'b0;
        e.opcode  = 1'b0;
        e.addr    = '0;
        e.miss    = mode ? 5'(miss) : 5'd0;
        e.bit_out = mode ? (5'(miss) >= thr) : msg;
        q.push_back(e);

        @(negedge clk);
        i_mode = mode; i_msg_bit = msg; i_base_addr = base;
        i_num_lines = k; i_threshold = thr; i_start = 1'b1;
        @(posedge clk);
        ncyc = 2 * int'(k) + 1;
        for (int c = 1; c <= ncyc; c++) begin
            @(negedge clk);
            i_start = (glitch == c);
            if (glitch == c) begin
                i_base_addr = 8'hAA; i_mode = ~mode; i_msg_bit = ~msg; i_num_lines = 5'd2;
            end
            i_retval = ((c % 2) == 0) ? retpat[(c - 2) / 2] : 1'($urandom);
            if (q.size() == 0) begin
                failures++; checks++;
                $display("FAIL %s scoreboard_empty cycle=%0d", tag, c);
            end else begin
                e = q.pop_front();
                checks++;
                if (o_busy !== e.busy) begin
                    failures++;
                    $display("FAIL %s busy cycle=%0d got=%b exp=%b", tag, c, o_busy, e.busy);
                end
                checks++;
                if (o_done !== e.is_done) begin
                    failures++;
                    $display("FAIL %s done cycle=%0d got=%b exp=%b", tag, c, o_done, e.is_done);
                end
                checks++;
                if (o_valid !== e.valid) begin
                    failures++;
                    $display("FAIL %s valid cycle=%0d got=%b exp=%b", tag, c, o_valid, e.valid);
                end
                if (e.busy) begin
                    checks++;
                    if (o_addr !== e.addr) begin
                        failures++;
                        $display("FAIL %s addr cycle=%0d got=%h exp=%h", tag, c, o_addr, e.addr);
                    end
                end
                if (e.valid) begin
                    checks++;
                    if (o_opcode !== e.opcode) begin
                        failures++;
                        $display("FAIL %s opcode cycle=%0d got=%b exp=%b", tag, c, o_opcode, e.opcode);
                    end
                end
                if (e.is_done) begin
                    checks++;
                    if (o_bit_out !== e.bit_out) begin
                        failures++;
                        $display("FAIL %s bit_out got=%b exp=%b", tag, o_bit_out, e.bit_out);
                    end
                    checks++;
                    if (o_miss_count !== e.miss) begin
                        failures++;
                        $display("FAIL %s miss_count got=%0d exp=%0d", tag, o_miss_count, e.miss);
                    end
                end
            end
        end
        @(negedge clk);
        i_start = 1'b0;
        checks++;
        if (o_busy !== 1'b0 || o_done !== 1'b0 || o_valid !== 1'b0) begin
            failures++;
            $display("FAIL %s idle_after busy/done/valid got=%b%b%b exp=000", tag, o_busy, o_done, o_valid);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        checks++;
        if ({o_opcode, o_addr, o_valid, o_busy, o_done, o_bit_out, o_miss_count} !== '0) begin
            failures++;
            $display("FAIL reset_outputs got=%b exp=0",
                     {o_opcode, o_addr, o_valid, o_busy, o_done, o_bit_out, o_miss_count});
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_send_one();
        run_txn(1'b0, 1'b1, 8'h10, 5'd3, 5'd0, 32'h0, 0, "send1");
    endtask

    task automatic test_send_zero();
        run_txn(1'b0, 1'b0, 8'h10, 5'd3, 5'd0, 32'h0, 0, "send0");
    endtask

    task automatic test_recv();
        run_txn(1'b1, 1'b0, 8'h20, 5'd4, 5'd2, 32'b1001, 0, "recv_hi");
        run_txn(1'b1, 1'b0, 8'h20, 5'd4, 5'd2, 32'b1101, 0, "recv_lo");
    endtask

    task automatic test_wrap();
        run_txn(1'b1, 1'b0, 8'hFE, 5'd4, 5'd1, 32'b1111, 0, "wrap");
    endtask

    task automatic test_zero_lines();
        run_txn(1'b1, 1'b0, 8'h33, 5'd0, 5'd0, 32'h0, 0, "zero_lines");
    endtask

    task automatic test_start_while_busy();
        run_txn(1'b0, 1'b1, 8'h40, 5'd3, 5'd0, 32'h0, 3, "start_busy");
    endtask

    task automatic test_async_reset();
        @(negedge clk);
        i_mode = 1'b1; i_msg_bit = 1'b0; i_base_addr = 8'h60;
        i_num_lines = 5'd4; i_threshold = 5'd1; i_start = 1'b1;
        @(posedge clk);
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            i_start  = 1'b0;
            i_retval = (c == 2) ? 1'b0 : 1'b1;
        end
        @(negedge clk);
        checks++;
        if (o_busy !== 1'b1 || o_valid !== 1'b1) begin
            failures++;
            $display("FAIL arst_pre busy/valid got=%b%b exp=11", o_busy, o_valid);
        end
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if ({o_opcode, o_addr, o_valid, o_busy, o_done, o_bit_out, o_miss_count} !== '0) begin
            failures++;
            $display("FAIL arst_outputs got=%b exp=0",
                     {o_opcode, o_addr, o_valid, o_busy, o_done, o_bit_out, o_miss_count});
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (o_busy !== 1'b0 || o_valid !== 1'b0 || o_done !== 1'b0) begin
            failures++;
            $display("FAIL arst_idle busy/valid/done got=%b%b%b exp=000", o_busy, o_valid, o_done);
        end
        run_txn(1'b1, 1'b0, 8'h50, 5'd2, 5'd1, 32'b01, 0, "post_rst");
    endtask

    initial begin
        i_start = 1'b0; i_mode = 1'b0; i_msg_bit = 1'b0; i_base_addr = '0;
        i_num_lines = '0; i_threshold = '0; i_retval = 1'b0;
        test_reset();
        test_send_one();
        test_send_zero();
        test_recv();
        test_wrap();
        test_zero_lines();
        test_start_while_busy();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
